wb_trace_monitor: RTL

Passive receiver for the CPU's writeback debug trace (`debug_wb_pc`, `debug_wb_rf_we`, `debug_wb_rf_wnum`, `debug_wb_rf_wdata`). It filters register-file write records, queues them in an on-chip FIFO, and drains them over a valid/ready stream to a host or debug port. It sits beside the CPU top and consumes its trace outputs. It provides PC-triggered arming, a sticky overflow flag, and drop and capture counters.

---
 rtl/trace_mon_pkg.sv | 27 ++
 rtl/wb_trace_monitor_if.sv | 38 +++
 rtl/trace_fifo.sv | 48 ++++
 rtl/wb_trace_monitor.sv | 123 ++++++++++++
 4 files changed

// File: rtl/trace_mon_pkg.sv
// rtl/trace_mon_pkg.sv - shared FSM encodings and trace record layout
// Record length depends on WB_TRACE_MONITOR_STAMP_EN.
package trace_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam int PC_W    = 32;
  localparam int WNUM_W  = 5;
  localparam int WDATA_W = 32;

  localparam int WDATA_OFF = 0;
  localparam int WNUM_OFF  = WDATA_OFF + WDATA_W;
  localparam int PC_OFF    = WNUM_OFF + WNUM_W;
  localparam int STAMP_OFF = PC_OFF + PC_W;

`ifdef WB_TRACE_MONITOR_STAMP_EN
  localparam int STAMP_W = 32;
  localparam int REC_W   = STAMP_OFF + STAMP_W;
`else
  localparam int REC_W   = STAMP_OFF;
`endif

endpackage

// File: rtl/wb_trace_monitor_if.sv
// rtl/wb_trace_monitor_if.sv - writeback trace input and record output stream
// out_stamp exists only with WB_TRACE_MONITOR_STAMP_EN.
interface wb_trace_monitor_if;
  import trace_mon_pkg::*;

  logic [PC_W-1:0]    debug_wb_pc;
  logic [3:0]         debug_wb_rf_we;
  logic [WNUM_W-1:0]  debug_wb_rf_wnum;
  logic [WDATA_W-1:0] debug_wb_rf_wdata;

  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [WNUM_W-1:0]  out_wnum;
  logic [WDATA_W-1:0] out_wdata;
`ifdef WB_TRACE_MONITOR_STAMP_EN
  logic [STAMP_W-1:0] out_stamp;
`endif

  modport master (
    output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, out_ready,
    input
`ifdef WB_TRACE_MONITOR_STAMP_EN
          out_stamp,
`endif
          out_valid, out_pc, out_wnum, out_wdata
  );

  modport slave (
    input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, out_ready,
    output
`ifdef WB_TRACE_MONITOR_STAMP_EN
           out_stamp,
`endif
           out_valid, out_pc, out_wnum, out_wdata
  );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic synchronous first-word-fall-through FIFO
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module trace_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         pop_ok, push_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (!resetn || clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop_ok)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wb_trace_monitor.sv
// rtl/wb_trace_monitor.sv - PC-triggered writeback trace capture into a drainable FIFO
// Optional per-record cycle stamp with WB_TRACE_MONITOR_STAMP_EN.
module wb_trace_monitor
  import trace_mon_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  wb_trace_monitor_if.slave      bus,
  input  logic                   arm,
  input  logic                   disarm,
  input  logic [31:0]            trig_pc,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       dropped_cnt,
  output logic [CNT_W-1:0]       captured_cnt,
  output logic [1:0]             state
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e             state_q, state_d;
  logic               qual, trig_hit, capture, pop_fire, drop, push_ok;
  logic               full, empty;
  logic [WDATA_W-1:0] wdata_masked;
  logic [REC_W-1:0]   rec_in, rec_out;
  logic [CNT_W-1:0]   dropped_q, captured_q;
  logic               overflow_q;

  assign qual     = (|bus.debug_wb_rf_we) && (bus.debug_wb_rf_wnum != '0);
  assign trig_hit = (state_q == ST_ARMED) && qual && (bus.debug_wb_pc == trig_pc);

  always_comb begin
    state_d = state_q;
    if (disarm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (arm) state_d = ST_ARMED;
        ST_ARMED: if (trig_hit) state_d = ST_CAPTURE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign capture  = (state_q == ST_CAPTURE && qual) || (trig_hit && !disarm);
  assign pop_fire = !empty && bus.out_ready;
  assign drop     = capture && full && !pop_fire;
  assign push_ok  = capture && !drop;

  always_comb begin
    for (int i = 0; i < 4; i++)
      wdata_masked[8*i +: 8] = bus.debug_wb_rf_we[i] ? bus.debug_wb_rf_wdata[8*i +: 8] : 8'h00;
  end

`ifdef WB_TRACE_MONITOR_STAMP_EN
  logic [STAMP_W-1:0] stamp_q;

  always_ff @(posedge clk) begin
    if (!resetn) stamp_q <= '0;
    else         stamp_q <= stamp_q + 32'd1;
  end
`endif

  always_comb begin
    rec_in = '0;
    rec_in[PC_OFF +: PC_W]       = bus.debug_wb_pc;
    rec_in[WNUM_OFF +: WNUM_W]   = bus.debug_wb_rf_wnum;
    rec_in[WDATA_OFF +: WDATA_W] = wdata_masked;
`ifdef WB_TRACE_MONITOR_STAMP_EN
    rec_in[STAMP_OFF +: STAMP_W] = stamp_q;
`endif
  end

  trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_ok),
    .pop_i   (pop_fire),
    .clear_i (clear),
    .wdata_i (rec_in),
    .rdata_o (rec_out),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      dropped_q  <= '0;
      captured_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok && captured_q != '1) captured_q <= captured_q + CNT_ONE;
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != '1) dropped_q <= dropped_q + CNT_ONE;
      end
    end
  end

  // Head fields read as zero whenever nothing is held.
  assign bus.out_valid = !empty;
  assign bus.out_pc    = empty ? '0 : rec_out[PC_OFF +: PC_W];
  assign bus.out_wnum  = empty ? '0 : rec_out[WNUM_OFF +: WNUM_W];
  assign bus.out_wdata = empty ? '0 : rec_out[WDATA_OFF +: WDATA_W];
`ifdef WB_TRACE_MONITOR_STAMP_EN
  assign bus.out_stamp = empty ? '0 : rec_out[STAMP_OFF +: STAMP_W];
`endif

  assign overflow     = overflow_q;
  assign dropped_cnt  = dropped_q;
  assign captured_cnt = captured_q;
  assign state        = state_q;

endmodule
